systolic_sequencer: RTL and testbench
=====================================

// Module: systolic_sequencer
// PURPOSE
//  Sequencer for the NxN output-stationary systolic_array. Holds operand matrices A and B
//  loaded over a write port. On start, clears the array, then drives A rows into datain and
//  B columns into weightin with the diagonal skew the array needs. Waits a drain window and
//  pulses done when macouti/macoutj are final. Sits between the host/loader and systolic_array.
// PARAMETERS
//  N          3   array dimension (lanes per bus)
//  DW         8   operand width per lane
//  DRAIN_CYC  8   zero-feed cycles after last operand before done (>=2N-1 for the array)
// PORTS
//  clk       in   1          clock
//  reset     in   1          synchronous, active-high
//  ld_we     in   1          write one operand element
//  ld_sel    in   1          0 = matrix A, 1 = matrix B
//  ld_row    in   clog2(N)   element row index
//  ld_col    in   clog2(N)   element column index
//  ld_data   in   DW         element value (unsigned)
//  start     in   1          begin a compute run (sampled in IDLE only)
//  arr_rst   out  1          drives systolic_array reset
//  datain    out  N*DW       lane i at [(N-i)*DW-1 -: DW]; lane 0 is MSB field
//  weightin  out  N*DW       same lane packing as datain
//  busy      out  1          high in every state except IDLE
//  done      out  1          one-cycle pulse when array outputs are final
// BEHAVIOUR
//  - One clock, clk. reset is synchronous and active-high.
//  - Reset: state IDLE. arr_rst, busy and done are 0. datain and weightin are 0.
//    A and B storage is cleared to 0. Reset during any state aborts the run the next edge.
//  - All outputs are registered.
//  - Loads: in IDLE, ld_we writes ld_data to A[ld_row][ld_col] or B[ld_row][ld_col].
//    The write is ignored when busy, or when ld_row>=N or ld_col>=N.
//  - FSM: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
//    IDLE : start=1 at an edge -> CLEAR at that edge. start is ignored in every other state.
//    CLEAR: 1 cycle. arr_rst=1, buses 0.
//    FEED : 2N-1 cycles, counter k=0..2N-2.
//    DRAIN: DRAIN_CYC cycles. Buses 0.
//    DONE : 1 cycle. done=1. Then IDLE. start seen in the DONE cycle is ignored.
//  - Skew in FEED cycle k:
//    datain lane i   = A[i][k-i] if 0<=k-i<N, else 0.
//    weightin lane j = B[k-j][j] if 0<=k-j<N, else 0.
//  - Timing: start sampled at edge t. Outputs show CLEAR in cycle t+1 and FEED k=0 in
//    cycle t+2. done is high in cycle t+2+(2N-1)+DRAIN_CYC.
//  - No arithmetic on operands; values pass through unmodified.
//  - Counter width is clog2(max(2N-1, DRAIN_CYC)+1).
//  - A and B may be reloaded after done; unchanged elements keep their values between runs.
// TESTING
//  1 Reset: assert reset mid-FEED. Next cycle busy=0, arr_rst=0, buses 0; state IDLE.
//    A subsequent run feeds zeros (storage cleared).
//  2 Skew: load A={1,2,3;4,5,6;7,8,9}, B={2,1,3;4,5,7;6,9,8}, pulse start.
//    After the arr_rst cycle, datain = {1,0,0},{2,4,0},{3,5,7},{0,6,8},{0,0,9}.
//    weightin = {2,0,0},{4,1,0},{6,5,3},{0,9,7},{0,0,8}. Then zeros.
//  3 Timing: with N=3 and DRAIN_CYC=8, start at edge t -> done exactly in cycle t+15,
//    one cycle wide. busy=1 from t+1 to t+15, 0 at t+16.
//  4 Lockout: pulse ld_we (A[0][0]=99) and start during FEED. Stored A and the run are
//    unaffected. No second run starts.
//  5 Bounds: ld_row=3 with N=3 -> no write. Checker confirms all A/B elements unchanged.
//  6 End-to-end: connect systolic_array and run scenario 2. At done, row 0 of results
//    = 28, 38, 41 (C=A*B).

Source files
------------

// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - operand store and skewed feed sequencer for an NxN output-stationary systolic array
//
// Purpose: holds operand matrices A and B written over a load port. A start pulse in IDLE
// clears the array for one cycle, streams A rows into datain and B columns into weightin
// with the diagonal skew the array expects, feeds zeros for a drain window, then pulses done.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset (aborts any run, clears A/B)
//   ld_we/ld_sel    write one element; ld_sel 0 = A, 1 = B (accepted in IDLE only)
//   ld_row/ld_col   element indices; out-of-range indices drop the write
//   ld_data         element value
//   start           begin a run (sampled in IDLE only)
//   arr_rst         array clear, high for the single CLEAR cycle
//   datain/weightin N lanes of DW bits each, lane 0 in the most significant field
//   busy            high in every state except IDLE
//   done            one-cycle pulse once the array outputs are final
module systolic_sequencer #(
   parameter int N         = 3,
   parameter int DW        = 8,
   parameter int DRAIN_CYC = 8,
   localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ld_we,
   input  logic            ld_sel,
   input  logic [IW-1:0]   ld_row,
   input  logic [IW-1:0]   ld_col,
   input  logic [DW-1:0]   ld_data,
   input  logic            start,
   output logic            arr_rst,
   output logic [N*DW-1:0] datain,
   output logic [N*DW-1:0] weightin,
   output logic            busy,
   output logic            done
);

   localparam int FEED_CYC = 2 * N - 1;
   localparam int CNT_MAX  = (FEED_CYC > DRAIN_CYC) ? FEED_CYC : DRAIN_CYC;
   localparam int CW       = $clog2(CNT_MAX + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FEED  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   a_q [N][N];
   logic [DW-1:0]   b_q [N][N];
   logic            arr_rst_q, busy_q, done_q;
   logic [N*DW-1:0] datain_q, datain_d;
   logic [N*DW-1:0] weightin_q, weightin_d;
   logic            ld_ok;
   logic [IW-1:0]   idx;

   assign ld_ok = ld_we && (state_q == S_IDLE) && (int'(ld_row) < N) && (int'(ld_col) < N);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            state_d = S_FEED;
            cnt_d   = '0;
         end
         S_FEED: begin
            if (cnt_q == CW'(FEED_CYC - 1)) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == CW'(DRAIN_CYC - 1)) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state, so the bus value for FEED step k
   // appears in the same cycle the FSM sits at step k.
   always_comb begin
      datain_d   = '0;
      weightin_d = '0;
      idx        = '0;
      if (state_d == S_FEED) begin
         for (int i = 0; i < N; i++) begin
            if ((int'(cnt_d) >= i) && (int'(cnt_d) - i < N)) begin
               idx = IW'(int'(cnt_d) - i);
               datain_d[(N-i)*DW-1 -: DW]   = a_q[i][idx];
               weightin_d[(N-i)*DW-1 -: DW] = b_q[idx][i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         arr_rst_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         datain_q   <= '0;
         weightin_q <= '0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               a_q[r][c] <= '0;
               b_q[r][c] <= '0;
            end
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         arr_rst_q  <= (state_d == S_CLEAR);
         busy_q     <= (state_d != S_IDLE);
         done_q     <= (state_d == S_DONE);
         datain_q   <= datain_d;
         weightin_q <= weightin_d;
         if (ld_ok) begin
            if (ld_sel) begin
               b_q[ld_row][ld_col] <= ld_data;
            end else begin
               a_q[ld_row][ld_col] <= ld_data;
            end
         end
      end
   end

   assign arr_rst  = arr_rst_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign datain   = datain_q;
   assign weightin = weightin_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - scoreboard bench for systolic_sequencer
module tb_systolic_sequencer;

   localparam int N = 3;
   localparam int DW = 8;
   localparam int DRAIN_CYC = 8;

   typedef struct packed {
      logic        rst;
      logic        dn;
      logic [23:0] d;
      logic [23:0] w;
   } exp_t;

   typedef logic [0:4][23:0] tab_t;

   logic        clk = 1'b0;
   logic        reset, ld_we, ld_sel, start;
   logic [1:0]  ld_row, ld_col;
   logic [7:0]  ld_data;
   logic        arr_rst, busy, done;
   logic [23:0] datain, weightin;

   exp_t exp_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   systolic_sequencer #(.N(N), .DW(DW), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk(clk), .reset(reset), .ld_we(ld_we), .ld_sel(ld_sel), .ld_row(ld_row),
      .ld_col(ld_col), .ld_data(ld_data), .start(start), .arr_rst(arr_rst),
      .datain(datain), .weightin(weightin), .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every busy cycle consumes one expected record; idle cycles must be quiet.
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_busy: got busy=1 expected no run at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("run_arr_rst", 64'(arr_rst), 64'(e.rst));
               chk("run_done", 64'(done), 64'(e.dn));
               chk("run_datain", 64'(datain), 64'(e.d));
               chk("run_weightin", 64'(weightin), 64'(e.w));
            end
         end else begin
            chk("idle_outputs", 64'({done, arr_rst, datain, weightin}), 64'd0);
         end
      end
   end

   task automatic load(input logic sel, input logic [1:0] row, input logic [1:0] col,
                       input logic [7:0] data);
      ld_we = 1'b1; ld_sel = sel; ld_row = row; ld_col = col; ld_data = data;
      @(posedge clk);
      #1 ld_we = 1'b0;
   endtask

   task automatic push_run(input tab_t d, input tab_t w);
      exp_q.push_back(exp_t'{1'b1, 1'b0, 24'h0, 24'h0});
      for (int k = 0; k < 5; k++) exp_q.push_back(exp_t'{1'b0, 1'b0, d[k], w[k]});
      for (int k = 0; k < DRAIN_CYC; k++) exp_q.push_back(exp_t'{1'b0, 1'b0, 24'h0, 24'h0});
      exp_q.push_back(exp_t'{1'b0, 1'b1, 24'h0, 24'h0});
   endtask

   // Start at edge t; the run must occupy exactly cycles t+1..t+15 and be idle at t+16.
   task automatic run(input tab_t d, input tab_t w, input bit lock);
      push_run(d, w);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (lock) begin
         repeat (3) @(posedge clk);
         #1;
         ld_we = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 8'd99;
         start = 1'b1;
         @(posedge clk);
         #1 ld_we = 1'b0; start = 1'b0;
         repeat (12) @(posedge clk);
      end else begin
         repeat (16) @(posedge clk);
      end
      @(negedge clk);
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
   endtask

   tab_t d2, w2, d2r, z, d_one, w_one;

   initial begin
      d2    = {24'h010000, 24'h020400, 24'h030507, 24'h000608, 24'h000009};
      w2    = {24'h020000, 24'h040100, 24'h060503, 24'h000907, 24'h000008};
      d2r   = {24'h0A0000, 24'h020400, 24'h030507, 24'h000608, 24'h000009};
      z     = '0;
      d_one = {24'h0, 24'h0, 24'h0, 24'h0000FF, 24'h0};
      w_one = {24'h0, 24'h0, 24'h000080, 24'h0, 24'h0};

      reset = 1'b1; ld_we = 1'b0; ld_sel = 1'b0; ld_row = '0; ld_col = '0;
      ld_data = '0; start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_arr_rst", 64'(arr_rst), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_datain", 64'(datain), 64'd0);
      chk("reset_weightin", 64'(weightin), 64'd0);
      reset = 1'b0;

      load(0, 0, 0, 1); load(0, 0, 1, 2); load(0, 0, 2, 3);
      load(0, 1, 0, 4); load(0, 1, 1, 5); load(0, 1, 2, 6);
      load(0, 2, 0, 7); load(0, 2, 1, 8); load(0, 2, 2, 9);
      load(1, 0, 0, 2); load(1, 0, 1, 1); load(1, 0, 2, 3);
      load(1, 1, 0, 4); load(1, 1, 1, 5); load(1, 1, 2, 7);
      load(1, 2, 0, 6); load(1, 2, 1, 9); load(1, 2, 2, 8);
      mon_en = 1'b1;

      // Skew and timing, with a write and a start attempted mid-FEED.
      run(d2, w2, 1'b1);
      // The locked-out write must not have landed.
      run(d2, w2, 1'b0);

      // Out-of-range writes are dropped.
      load(0, 2'd3, 2'd0, 8'd77);
      load(1, 2'd0, 2'd3, 8'd77);
      load(0, 2'd3, 2'd3, 8'd77);
      run(d2, w2, 1'b0);

      // Reload a single element; everything else keeps its value.
      load(0, 0, 0, 8'h0A);
      run(d2r, w2, 1'b0);

      // Reset in the middle of FEED.
      mon_en = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_arr_rst", 64'(arr_rst), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_datain", 64'(datain), 64'd0);
      chk("midrst_weightin", 64'(weightin), 64'd0);
      reset = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1 mon_en = 1'b1;

      // Storage was cleared, so the next run feeds zeros.
      run(z, z, 1'b0);

      // Single full-scale elements at the corners of the skew.
      load(0, 2, 1, 8'hFF);
      load(1, 0, 2, 8'h80);
      run(d_one, w_one, 1'b0);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
